// File: rtl/onehot_decoder_3_8.sv
// rtl/onehot_decoder_3_8.sv - 3-to-8 one-hot decoder with timed-pulse, gap and level-hold modes
//
// Ports:
//    clk         in   clock, rising-edge
//    rst         in   asynchronous active-high reset
//    code        in   [2:0] binary index to decode
//    code_valid  in   code/pulse_len valid this cycle
//    code_ready  out  block can accept a code this cycle (combinational)
//    pulse_len   in   [PULSE_W-1:0] high duration in cycles, 0 = level (hold) mode
//    clear       in   synchronous flush back to IDLE with y = 0
//    y           out  [7:0] registered one-hot output
//    y_valid     out  registered, equals |y
//    busy        out  high in DRIVE or GAP
//    last_code   out  [2:0] most recently accepted code
//    accept_cnt  out  [7:0] accepted-code count, wraps at 256
module onehot_decoder_3_8 #(
   parameter int PULSE_W    = 4,
   parameter int GAP_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2:0]         code,
   input  logic               code_valid,
   output logic               code_ready,
   input  logic [PULSE_W-1:0] pulse_len,
   input  logic               clear,
   output logic [7:0]         y,
   output logic               y_valid,
   output logic               busy,
   output logic [2:0]         last_code,
   output logic [7:0]         accept_cnt
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DRIVE = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   localparam logic [3:0]         GAP_LOAD = 4'(GAP_CYCLES);
   localparam logic [PULSE_W-1:0] CNT_ONE  = PULSE_W'(1);
   localparam logic [PULSE_W-1:0] CNT_ZERO = '0;

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic [PULSE_W-1:0] r_cnt;
   logic [PULSE_W-1:0] w_cnt_nxt;
   logic [3:0]         r_gap;
   logic [3:0]         w_gap_nxt;
   logic [7:0]         r_y;
   logic [7:0]         w_y_nxt;
   logic               r_y_valid;
   logic [2:0]         r_last_code;
   logic [7:0]         r_accept_cnt;
   logic               w_accept;
   logic [7:0]         w_onehot;

   assign code_ready = ((r_state == S_IDLE) || (r_state == S_HOLD)) && !clear;
   assign w_accept   = code_valid && code_ready;
   assign w_onehot   = 8'b1 << code;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_gap_nxt   = r_gap;
      w_y_nxt     = r_y;
      if (clear) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = CNT_ZERO;
         w_gap_nxt   = 4'd0;
         w_y_nxt     = 8'h00;
      end else begin
         case (r_state)
            S_IDLE, S_HOLD: begin
               // From HOLD a new accept overwrites y directly, so the output
               // never drops to zero between two held or driven codes.
               if (w_accept) begin
                  w_y_nxt = w_onehot;
                  if (pulse_len != CNT_ZERO) begin
                     w_state_nxt = S_DRIVE;
                     w_cnt_nxt   = pulse_len;
                  end else begin
                     w_state_nxt = S_HOLD;
                  end
               end
            end
            S_DRIVE: begin
               // Counter holds the cycles still to drive including this one.
               if (r_cnt <= CNT_ONE) begin
                  w_cnt_nxt   = CNT_ZERO;
                  w_y_nxt     = 8'h00;
                  w_gap_nxt   = GAP_LOAD;
                  w_state_nxt = (GAP_LOAD != 4'd0) ? S_GAP : S_IDLE;
               end else begin
                  w_cnt_nxt = r_cnt - CNT_ONE;
               end
            end
            S_GAP: begin
               w_y_nxt = 8'h00;
               if (r_gap <= 4'd1) begin
                  w_gap_nxt   = 4'd0;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_gap_nxt = r_gap - 4'd1;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_y_nxt     = 8'h00;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= CNT_ZERO;
         r_gap        <= 4'd0;
         r_y          <= 8'h00;
         r_y_valid    <= 1'b0;
         r_last_code  <= 3'd0;
         r_accept_cnt <= 8'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_gap     <= w_gap_nxt;
         r_y       <= w_y_nxt;
         r_y_valid <= |w_y_nxt;
         if (w_accept) begin
            r_last_code  <= code;
            r_accept_cnt <= r_accept_cnt + 8'd1;
         end
      end
   end

   assign y          = r_y;
   assign y_valid    = r_y_valid;
   assign busy       = (r_state == S_DRIVE) || (r_state == S_GAP);
   assign last_code  = r_last_code;
   assign accept_cnt = r_accept_cnt;

endmodule

// File: tb/tb_onehot_decoder_3_8.sv
// tb/tb_onehot_decoder_3_8.sv - self-checking bench for onehot_decoder_3_8
module tb_onehot_decoder_3_8;

   localparam int PW  = 4;
   localparam int GAP = 1;

   logic          clk;
   logic          rst;
   logic [2:0]    code;
   logic          code_valid;
   logic          code_ready;
   logic [PW-1:0] pulse_len;
   logic          clear;
   logic [7:0]    y;
   logic          y_valid;
   logic          busy;
   logic [2:0]    last_code;
   logic [7:0]    accept_cnt;

   onehot_decoder_3_8 #(.PULSE_W(PW), .GAP_CYCLES(GAP)) dut (
      .clk        (clk),
      .rst        (rst),
      .code       (code),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .pulse_len  (pulse_len),
      .clear      (clear),
      .y          (y),
      .y_valid    (y_valid),
      .busy       (busy),
      .last_code  (last_code),
      .accept_cnt (accept_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: a schedule of future output values. A timed accept
   // queues pulse_len copies of the one-hot value followed by GAP zeros;
   // the block is busy while anything is queued. Level mode keeps a held value.
   logic [7:0] sched[$];
   logic       m_hold;
   logic [7:0] m_hold_y;
   logic [7:0] m_cnt;
   logic [2:0] m_last;

   task automatic model_reset();
      sched.delete();
      m_hold   = 1'b0;
      m_hold_y = 8'h00;
      m_cnt    = 8'd0;
      m_last   = 3'd0;
   endtask

   function automatic logic [7:0] exp_y();
      if (sched.size() != 0) return sched[0];
      return m_hold ? m_hold_y : 8'h00;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge: drive inputs, check outputs, advance the model
   // across the rising edge, return at the next falling edge.
   task automatic step(input logic v, input logic [2:0] c, input logic [PW-1:0] pl, input logic clr);
      logic       acc;
      logic [7:0] ey;
      logic [7:0] junk;
      code_valid = v;
      code       = c;
      pulse_len  = pl;
      clear      = clr;
      #1;
      ey = exp_y();
      check("y", {24'd0, y}, {24'd0, ey});
      check("y_valid", {31'd0, y_valid}, {31'd0, (ey != 8'h00)});
      check("busy", {31'd0, busy}, {31'd0, (sched.size() != 0)});
      check("code_ready", {31'd0, code_ready}, {31'd0, (sched.size() == 0) && !clr});
      check("last_code", {29'd0, last_code}, {29'd0, m_last});
      check("accept_cnt", {24'd0, accept_cnt}, {24'd0, m_cnt});
      check("onehot0", {31'd0, $onehot0(y)}, 32'd1);
      acc = v && !clr && (sched.size() == 0);
      @(posedge clk);
      if (clr) begin
         sched.delete();
         m_hold = 1'b0;
      end else if (acc) begin
         m_cnt  = m_cnt + 8'd1;
         m_last = c;
         if (pl != 0) begin
            m_hold = 1'b0;
            for (int k = 0; k < int'(pl); k++) sched.push_back(8'(2 ** int'(c)));
            for (int k = 0; k < GAP; k++) sched.push_back(8'h00);
         end else begin
            m_hold   = 1'b1;
            m_hold_y = 8'(2 ** int'(c));
         end
      end else if (sched.size() != 0) begin
         junk = sched.pop_front();
      end
      @(negedge clk);
   endtask

   initial begin
      rst        = 1'b1;
      code       = 3'd0;
      code_valid = 1'b0;
      pulse_len  = '0;
      clear      = 1'b0;
      model_reset();
      #2;
      check("rst_y", {24'd0, y}, 32'd0);
      check("rst_y_valid", {31'd0, y_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_cnt", {24'd0, accept_cnt}, 32'd0);
      check("rst_last", {29'd0, last_code}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Timed pulse code=5 len=3
      step(1'b1, 3'd5, 4'd3, 1'b0);
      check("pulse_t1_y", {24'd0, y}, 32'h20);
      step(1'b0, 3'd0, 4'd0, 1'b0);
      step(1'b0, 3'd0, 4'd0, 1'b0);
      step(1'b0, 3'd0, 4'd0, 1'b0);
      check("pulse_gap_busy", {31'd0, busy}, 32'd1);
      check("pulse_gap_y", {24'd0, y}, 32'd0);
      step(1'b0, 3'd0, 4'd0, 1'b0);
      check("pulse_ready", {31'd0, code_ready}, 32'd1);
      check("pulse_cnt", {24'd0, accept_cnt}, 32'd1);
      step(1'b0, 3'd0, 4'd0, 1'b0);

      // Level mode hold then replace
      step(1'b1, 3'd2, 4'd0, 1'b0);
      for (int i = 0; i < 50; i++) step(1'b0, 3'd0, 4'd0, 1'b0);
      step(1'b1, 3'd7, 4'd0, 1'b0);
      check("hold_replace_y", {24'd0, y}, 32'h80);
      step(1'b0, 3'd0, 4'd0, 1'b0);

      // Backpressure: valid held through DRIVE/GAP
      for (int i = 0; i < 12; i++) step(1'b1, 3'd1, 4'd2, 1'b0);
      step(1'b0, 3'd0, 4'd0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 4'd0, 1'b0);

      // clear with valid in HOLD
      step(1'b1, 3'd4, 4'd0, 1'b0);
      check("hold_10", {24'd0, y}, 32'h10);
      step(1'b1, 3'd3, 4'd0, 1'b1);
      check("clear_y", {24'd0, y}, 32'd0);
      check("clear_last", {29'd0, last_code}, 32'd4);
      step(1'b0, 3'd0, 4'd0, 1'b0);

      // Asynchronous reset mid-DRIVE
      step(1'b1, 3'd6, 4'd15, 1'b0);
      step(1'b0, 3'd0, 4'd0, 1'b0);
      step(1'b0, 3'd0, 4'd0, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("arst_y", {24'd0, y}, 32'd0);
      check("arst_y_valid", {31'd0, y_valid}, 32'd0);
      check("arst_cnt", {24'd0, accept_cnt}, 32'd0);
      check("arst_last", {29'd0, last_code}, 32'd0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 3'd0, 4'd0, 1'b0);

      // 256 back-to-back level accepts, accept_cnt wraps
      for (int i = 0; i < 256; i++) begin
         step(1'b1, 3'(i % 8), 4'd0, 1'b0);
         check("level_y_last", {24'd0, y}, {24'd0, 8'(2 ** int'(last_code))});
      end
      check("wrap_cnt", {24'd0, accept_cnt}, 32'd0);
      step(1'b0, 3'd0, 4'd0, 1'b0);

      // Random traffic
      for (int i = 0; i < 2000; i++) begin
         logic          rv;
         logic [2:0]    rc;
         logic [PW-1:0] rp;
         logic          rcl;
         rv  = ($urandom % 3) != 0;
         rc  = 3'($urandom % 8);
         rp  = (($urandom % 4) == 0) ? PW'($urandom % 16) : PW'($urandom % 3);
         rcl = ($urandom % 20) == 0;
         step(rv, rc, rp, rcl);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
